dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 10, word-address width (1024-word data memory).
REQ-002 Parameter DW, default 32, data word width.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 core_req  in  1  core load/store request; held with command until core_gnt.
REQ-006 core_we  in  1  core command: 1 = store, 0 = load.
REQ-007 core_addr  in  AW  core word address.
REQ-008 core_wdata  in  DW  core store data.
REQ-009 core_gnt  out  1  one-cycle pulse: core command issued to memory.
REQ-010 core_rvalid  out  1  one-cycle pulse: rdata holds core load result.
REQ-011 dbg_req / dbg_we / dbg_addr / dbg_wdata  in  1/1/AW/DW  debug-loader requester, same meanings as core_*.
REQ-012 dbg_gnt / dbg_rvalid  out  1/1  debug-loader grant and read-valid pulses.
REQ-013 rdata  out  DW  shared load data, meaningful only while a *_rvalid is high.
REQ-014 mem_en / mem_we  out  1/1  memory access strobe and write enable.
REQ-015 mem_addr / mem_wdata  out  AW/DW  memory address and write data.
REQ-016 mem_rdata  in  DW  memory read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT; one transaction in flight at most.
REQ-018 IDLE: if any req high, register winner, we, addr, wdata -> ISSUE; else stay IDLE.
REQ-019 Requests sampled only in IDLE; req in ISSUE/WAIT ignored until return to IDLE.
REQ-020 Arbitration round-robin: single request wins; both high -> requester not granted last wins.
REQ-021 Last-winner pointer updates on every entry to ISSUE; after reset pointer = dbg, so core wins first tie.
REQ-022 ISSUE: mem_en=1, mem_we=registered we, mem_addr/mem_wdata=registered values; winner *_gnt=1 this cycle only.
REQ-023 ISSUE -> WAIT on load, ISSUE -> IDLE on store.
REQ-024 WAIT: rdata=mem_rdata, winner *_rvalid=1 for exactly one cycle; -> IDLE.
REQ-025 Latency from req sampled in cycle N: gnt and mem_en in N+1; load rvalid in N+2; next sample at N+2 (store) or N+3 (load).
REQ-026 Requester must drop or replace req by the cycle after its gnt; a req still high in IDLE is a new request.
REQ-027 mem_en, mem_we, all gnt and rvalid low outside ISSUE/WAIT as stated; never two gnt or two rvalid high together.
REQ-028 mem_we never high while mem_en low; addresses pass unmodified (no wrap/offset arithmetic).

Reset
REQ-029 reset high at an edge: next state IDLE, pointer = dbg, all outputs 0 (rdata 0), registered command cleared.
REQ-030 reset during ISSUE or WAIT aborts transaction: no gnt or rvalid issued for it afterwards; no memory write if reset coincides with would-be ISSUE.

Structure
REQ-031 Shared package holds FSM state encoding (IDLE=0, ISSUE=1, WAIT=2), requester IDs (CORE=0, DBG=1), AW/DW defaults.
REQ-032 One sub-module, rr_pick2: combinational two-way round-robin pick from (req vector, last pointer); FSM and registers in dmem_arbiter.

Verification
REQ-033 Core store alone: core_req=1,we=1,addr=5,wdata=0xA5 at N -> N+1 mem_en=1,mem_we=1,addr 5,data 0xA5,core_gnt=1; N+2 all low.
REQ-034 Core load: addr 5 after REQ-033 store -> N+1 core_gnt, N+2 core_rvalid=1, rdata=0xA5, dbg_rvalid=0.
REQ-035 Tie after reset: both req loads held continuously -> grant order core, dbg, core, dbg; each rvalid to matching port.
REQ-036 Debug load addr 1023 with core idle -> mem_addr=1023, dbg_gnt N+1, dbg_rvalid N+2; core outputs stay 0.
REQ-037 Reset asserted in ISSUE cycle of core load -> no core_rvalid follows, all outputs 0 next cycle, next tie goes to core.
REQ-038 Assertions all runs: gnt/rvalid one-hot-or-zero, mem_we implies mem_en, rvalid only in cycle after load gnt.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared state encoding, requester IDs and width defaults for the data-memory arbiter
package dmem_arbiter_pkg;
  localparam int AW_DEF = 10;
  localparam int DW_DEF = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_e;
  typedef enum logic {CORE = 1'b0, DBG = 1'b1} rid_e;
endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick, a tie goes to whoever did not win last
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  rid_e       last_i,
  output rid_e       pick_o
);
  // lone request wins outright; on a tie the pointer is flipped
  always_comb pick_o = &req_i ? rid_e'(~last_i) : rid_e'(req_i[1]);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core and the debug loader
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  state_e        state_q;
  rid_e          last_q, pick;
  logic          en_q, we_q, sel_we;
  logic [AW-1:0] addr_q, sel_addr;
  logic [DW-1:0] wdata_q, sel_wdata;
  logic [1:0]    gnt_q, rvalid_q;
  rr_pick2 u_pick (.req_i({dbg_req, core_req}), .last_i(last_q), .pick_o(pick));
  // command of whichever requester the picker chose
  always_comb begin
    sel_we    = pick == DBG ? dbg_we : core_we;
    sel_addr  = pick == DBG ? dbg_addr : core_addr;
    sel_wdata = pick == DBG ? dbg_wdata : core_wdata;
  end
  // sequencer: sample in IDLE, drive memory for one ISSUE cycle, WAIT one cycle for load data
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= DBG;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (core_req | dbg_req) begin
          state_q <= ISSUE;
          last_q  <= pick;
          en_q    <= 1'b1;
          we_q    <= sel_we;
          addr_q  <= sel_addr;
          wdata_q <= sel_wdata;
          gnt_q   <= pick == DBG ? 2'b10 : 2'b01;
        end
        ISSUE: begin
          state_q  <= we_q ? IDLE : WAIT;
          en_q     <= 1'b0;
          we_q     <= 1'b0;
          addr_q   <= '0;
          wdata_q  <= '0;
          gnt_q    <= '0;
          rvalid_q <= we_q ? 2'b00 : gnt_q;
        end
        default: begin
          state_q  <= IDLE;
          rvalid_q <= '0;
        end
      endcase
    end
  end
  assign mem_en      = en_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign core_gnt    = gnt_q[0];
  assign dbg_gnt     = gnt_q[1];
  assign core_rvalid = rvalid_q[0];
  assign dbg_rvalid  = rvalid_q[1];
  assign rdata       = |rvalid_q ? mem_rdata : '0;
endmodule
